bisect_sqrt: RTL and testbench

BISECT_SQRT -- requirements
Module: bisect_sqrt

---
 rtl/bisect_sqrt.sv | 166 ++++++++++++++++
 tb/tb_bisect_sqrt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bisect_sqrt.sv
// -----------------------------------------------------------------------------
// bisect_sqrt
//
// Integer square root by bisection. Returns the largest x in 0..255 with
// x*x <= target. Every midpoint lo + half is produced by an external adder
// whose latency is ADD_LATENCY cycles (0 = combinational). The multiply and
// compare are done internally.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   start       request a new run (only honoured in IDLE)
//   target      16-bit unsigned radicand, captured when start is accepted
//   add_a       adder operand A (interval low bound lo)
//   add_b       adder operand B (half-span of the interval)
//   add_sum     adder result add_a + add_b
//   busy        high from the cycle after an accepted start until DONE is left
//   done        one-cycle pulse while the result is valid
//   root        floor(sqrt(target)), held until the next run completes
//   iter_count  bisection iterations completed in the current or last run
//
// State table
//   IDLE  | waiting for start; operands parked at 0
//   ISSUE | operands for this iteration presented to the adder
//   WAIT  | ADD_LATENCY cycles for the adder result
//   EVAL  | mid = add_sum, square and compare, narrow [lo, hi]
//   DONE  | root valid, done pulse, operands parked at 0
// -----------------------------------------------------------------------------
module bisect_sqrt #(
    parameter int ADD_LATENCY = 1   // legal range 0..3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] target,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    input  logic [7:0]  add_sum,
    output logic        busy,
    output logic        done,
    output logic [7:0]  root,
    output logic [3:0]  iter_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // WAIT is a down-counter that exits when it reaches zero, so it is
    // loaded with one less than the number of wait cycles.
    localparam logic [1:0] WAIT_LOAD = (ADD_LATENCY > 0) ? 2'(ADD_LATENCY - 1) : 2'd0;

    state_t      state;
    logic [15:0] tgt;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  wait_cnt;

    logic [7:0]  mid;
    logic [15:0] mid_sq;
    logic        fits;
    logic [7:0]  lo_nxt;
    logic [7:0]  hi_nxt;
    logic [8:0]  span_nxt;
    logic [7:0]  half_nxt;

    // Interval update for EVAL. The span is formed in 9 bits because the
    // initial interval 0..255 holds 256 values. A failing compare implies
    // mid >= 1 (0*0 <= any target), so mid - 1 cannot wrap.
    always_comb begin
        mid      = add_sum;
        mid_sq   = 16'(mid) * 16'(mid);
        fits     = (mid_sq <= tgt);
        lo_nxt   = fits ? mid : lo;
        hi_nxt   = fits ? hi  : (mid - 8'd1);
        span_nxt = {1'b0, hi_nxt} - {1'b0, lo_nxt} + 9'd1;
        half_nxt = span_nxt[8:1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tgt        <= '0;
            lo         <= '0;
            hi         <= '0;
            wait_cnt   <= '0;
            add_a      <= '0;
            add_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            root       <= '0;
            iter_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tgt        <= target;
                        lo         <= 8'd0;
                        hi         <= 8'd255;
                        iter_count <= 4'd0;
                        busy       <= 1'b1;
                        // Operands are registered on the way into ISSUE so
                        // they are already stable for the whole ISSUE cycle.
                        add_a      <= 8'd0;
                        add_b      <= 8'd128;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (ADD_LATENCY == 0) begin
                        state <= EVAL;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= EVAL;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                EVAL: begin
                    lo         <= lo_nxt;
                    hi         <= hi_nxt;
                    iter_count <= iter_count + 4'd1;
                    if (lo_nxt == hi_nxt) begin
                        root  <= lo_nxt;
                        done  <= 1'b1;
                        add_a <= 8'd0;
                        add_b <= 8'd0;
                        state <= DONE;
                    end else begin
                        add_a <= lo_nxt;
                        add_b <= half_nxt;
                        state <= ISSUE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    add_a <= '0;
                    add_b <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bisect_sqrt.sv
// -----------------------------------------------------------------------------
// tb_bisect_sqrt
//
// Three instances with adder latencies 0, 1 and 3, each with its own adder
// model. Expected roots come from a hand-computed table or from a linear
// integer square root reference; timing expectations come from 8*(2+L)+1.
// Edge indices: the posedge that accepts start is edge 0; the negedge after
// edge k-1 is index k and shows the value that edge k samples.
// -----------------------------------------------------------------------------
module tb_bisect_sqrt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] target;
    logic        start0, start1, start3;
    logic [7:0]  a0, b0, s0, r0;
    logic [7:0]  a1, b1, s1, r1;
    logic [7:0]  a3, b3, s3, r3;
    logic [7:0]  p3_0, p3_1;
    logic        d0, d1, d3, y0, y1, y3;
    logic [3:0]  i0, i1, i3;

    int n_checks = 0;
    int n_fail   = 0;

    bisect_sqrt #(.ADD_LATENCY(0)) u_lat0 (
        .clock(clk), .reset(rst_n), .start(start0), .target(target),
        .add_a(a0), .add_b(b0), .add_sum(s0),
        .busy(y0), .done(d0), .root(r0), .iter_count(i0));

    bisect_sqrt #(.ADD_LATENCY(1)) u_lat1 (
        .clock(clk), .reset(rst_n), .start(start1), .target(target),
        .add_a(a1), .add_b(b1), .add_sum(s1),
        .busy(y1), .done(d1), .root(r1), .iter_count(i1));

    bisect_sqrt #(.ADD_LATENCY(3)) u_lat3 (
        .clock(clk), .reset(rst_n), .start(start3), .target(target),
        .add_a(a3), .add_b(b3), .add_sum(s3),
        .busy(y3), .done(d3), .root(r3), .iter_count(i3));

    // Adder models: combinational, one register, three-register delay line.
    assign s0 = a0 + b0;
    always @(posedge clk) s1 <= a1 + b1;
    always @(posedge clk) begin
        p3_0 <= a3 + b3;
        p3_1 <= p3_0;
        s3   <= p3_1;
    end

    typedef struct {
        logic [15:0] t;
        logic [7:0]  r;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start0 = v;
            1:       start1 = v;
            default: start3 = v;
        endcase
    endtask

    task automatic sample(input int sel, output logic d, output logic y,
                          output logic [7:0] r, output logic [7:0] a,
                          output logic [7:0] b, output logic [3:0] it);
        case (sel)
            0:       begin d = d0; y = y0; r = r0; a = a0; b = b0; it = i0; end
            1:       begin d = d1; y = y1; r = r1; a = a1; b = b1; it = i1; end
            default: begin d = d3; y = y3; r = r3; a = a3; b = b3; it = i3; end
        endcase
    endtask

    function automatic logic [7:0] isqrt_ref(input int t);
        int x = 0;
        while (x < 255 && (x + 1) * (x + 1) <= t) x++;
        return 8'(x);
    endfunction

    // One run on instance sel (0 -> L=0, 1 -> L=1, 2 -> L=3). Returns at the
    // negedge where done is high. from_done: called at a DONE negedge, so the
    // start raised there must be ignored and taken one cycle later.
    task automatic run_any(input int sel, input logic [15:0] t, input bit from_done,
                           input bit disturb, input logic [7:0] exp_root,
                           input logic [7:0] old_root, input string tag);
        int lat;
        int p;
        int exp_edge;
        int idx = 0;
        bit ok = 1'b1;
        logic d, y;
        logic [7:0] r, a, b, pa, pb;
        logic [3:0] it;
        lat      = (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
        p        = 2 + lat;
        exp_edge = 8 * p + 1;
        pa = '0;
        pb = '0;
        target = t;
        set_start(sel, 1'b1);
        if (from_done) begin
            @(negedge clk);
            sample(sel, d, y, r, a, b, it);
            chk({tag, " start_in_done_ignored busy"}, 32'(y), 32'd0);
        end
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int i = 1; i <= exp_edge + 20; i++) begin
            if (i > 1) @(negedge clk);
            if (disturb) begin
                if (i == 3 || i == 10) set_start(sel, 1'b1);
                if (i == 4 || i == 11) set_start(sel, 1'b0);
                if (i == 5) target = 16'd9;
            end
            sample(sel, d, y, r, a, b, it);
            if (i == 1) begin
                chk({tag, " busy_after_accept"}, 32'(y), 32'd1);
                chk({tag, " first_operands"}, 32'({a, b}), 32'({8'd0, 8'd128}));
                chk({tag, " root_held_during_run"}, 32'(r), 32'(old_root));
            end else if (i <= 8 * p && ((i - 1) % p) != 0 && (a !== pa || b !== pb)) begin
                ok = 1'b0;
            end
            pa = a;
            pb = b;
            if (d === 1'b1) begin
                idx = i;
                break;
            end
        end
        chk({tag, " done_edge"}, 32'(idx), 32'(exp_edge));
        chk({tag, " root"}, 32'(r), 32'(exp_root));
        chk({tag, " iter_count"}, 32'(it), 32'd8);
        chk({tag, " operands_zero_in_done"}, 32'({a, b}), 32'd0);
        chk({tag, " operands_stable"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d, y;
        logic [7:0] r, a, b, prev, er;
        logic [3:0] it;
        logic [15:0] rt;
        int cnt;

        vecs[0]  = '{16'd144,   8'd12};
        vecs[1]  = '{16'd143,   8'd11};
        vecs[2]  = '{16'd0,     8'd0};
        vecs[3]  = '{16'd65535, 8'd255};
        vecs[4]  = '{16'd65024, 8'd254};
        vecs[5]  = '{16'd1,     8'd1};
        vecs[6]  = '{16'd3,     8'd1};
        vecs[7]  = '{16'd4,     8'd2};
        vecs[8]  = '{16'd255,   8'd15};
        vecs[9]  = '{16'd256,   8'd16};
        vecs[10] = '{16'd1000,  8'd31};
        vecs[11] = '{16'd65025, 8'd255};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        target = 16'd0;
        repeat (3) @(negedge clk);
        sample(1, d, y, r, a, b, it);
        chk("reset busy", 32'(y), 32'd0);
        chk("reset done", 32'(d), 32'd0);
        chk("reset root", 32'(r), 32'd0);
        chk("reset operands", 32'({a, b}), 32'd0);
        chk("reset iter_count", 32'(it), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        prev = 8'd0;
        for (int k = 0; k < 12; k++) begin
            run_any(1, vecs[k].t, 1'b0, 1'b0, vecs[k].r, prev, $sformatf("vec%0d", k));
            prev = vecs[k].r;
            @(negedge clk);
            sample(1, d, y, r, a, b, it);
            chk($sformatf("vec%0d busy_after_done", k), 32'(y), 32'd0);
            chk($sformatf("vec%0d done_one_cycle", k), 32'(d), 32'd0);
        end

        // Back-to-back: start raised during DONE, taken in the next IDLE.
        run_any(1, 16'd100, 1'b0, 1'b0, 8'd10, prev, "b2b_first");
        run_any(1, 16'd49, 1'b1, 1'b0, 8'd7, 8'd10, "b2b_second");
        @(negedge clk);

        // start re-pulsed while busy and target changed mid-run.
        run_any(1, 16'd400, 1'b0, 1'b1, 8'd20, 8'd7, "disturb");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d1 === 1'b1) cnt++;
        end
        chk("disturb single_done", 32'(cnt), 32'd0);

        // Reset asserted at cycle 12 of a run.
        target = 16'd1000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sample(1, d, y, r, a, b, it);
        chk("midrun_reset busy", 32'(y), 32'd0);
        chk("midrun_reset done", 32'(d), 32'd0);
        chk("midrun_reset root", 32'(r), 32'd0);
        chk("midrun_reset operands", 32'({a, b}), 32'd0);
        chk("midrun_reset iter_count", 32'(it), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d1 === 1'b1) cnt++;
        end
        chk("midrun_reset no_done", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_any(1, 16'd81, 1'b0, 1'b0, 8'd9, 8'd0, "after_reset");

        // Adder latency 0 and 3.
        @(negedge clk);
        run_any(0, 16'd1000, 1'b0, 1'b0, 8'd31, 8'd0, "lat0");
        @(negedge clk);
        run_any(2, 16'd1000, 1'b0, 1'b0, 8'd31, 8'd0, "lat3");
        @(negedge clk);

        // Random targets, back-to-back on the latency-1 instance.
        prev = 8'd9;
        for (int k = 0; k < 6; k++) begin
            rt = 16'($urandom_range(65535, 1000));
            er = isqrt_ref(int'(rt));
            run_any(1, rt, (k > 0), 1'b0, er, prev, $sformatf("rand%0d_t%0d", k, rt));
            prev = er;
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
